// File: rtl/swd_target_pkg.sv
// swd_target_pkg: shared states, ACK codes, request bit positions and defaults for the SWD target engine.
package swd_target_pkg;
    localparam int LINE_RESET_CYCLES_DEFAULT = 50;

    typedef enum logic [3:0] {LRST, IDLE, REQ, TRN1, ACK, RDATA, TRN2, WTRN, WDATA} state_t;

    localparam logic [2:0] OK    = 3'b001;
    localparam logic [2:0] WAIT  = 3'b010;
    localparam logic [2:0] FAULT = 3'b100;

    localparam int REQ_APNDP = 0;
    localparam int REQ_RNW   = 1;
    localparam int REQ_A2    = 2;
    localparam int REQ_A3    = 3;
    localparam int REQ_PAR   = 4;
    localparam int REQ_STOP  = 5;
    localparam int REQ_PARK  = 6;
endpackage

// File: rtl/swd_line_reset_detector.sv
// swd_line_reset_detector: saturating count of host-driven 1s; pulses line_reset_seen once per run.
module swd_line_reset_detector
    import swd_target_pkg::*;
#(
    parameter int LINE_RESET_CYCLES = LINE_RESET_CYCLES_DEFAULT
) (
    input  logic swclk,
    input  logic rst,
    input  logic swdio_in,
    input  logic swdio_oe,
    output logic sat,
    output logic hit,
    output logic line_reset_seen
);
    localparam int W = $clog2(LINE_RESET_CYCLES + 1);
    localparam logic [W-1:0] MAX = W'(LINE_RESET_CYCLES);

    logic [W-1:0] cnt;

    assign sat = cnt == MAX;
    // The target's own driven bits are not host 1s, so they never advance the count.
    assign hit = !swdio_oe && swdio_in && cnt == MAX - 1'b1;

    always_ff @(posedge swclk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            line_reset_seen <= 1'b0;
        end else begin
            cnt             <= (swdio_oe || !swdio_in) ? '0 : sat ? cnt : cnt + 1'b1;
            line_reset_seen <= hit;
        end
    end
endmodule

// File: rtl/swd_target_responder.sv
// swd_target_responder: target-side SWD engine decoding host requests, returning ACK/read data and capturing writes.
// Define SWD_WDATA_PARITY_CHECK_EN to reject write data whose parity bit mismatches.
module swd_target_responder
    import swd_target_pkg::*;
#(
    parameter int LINE_RESET_CYCLES = LINE_RESET_CYCLES_DEFAULT
) (
    input  logic        swclk,
    input  logic        rst,
    input  logic        swdio_in,
    output logic        swdio_out,
    output logic        swdio_oe,
    output logic        cmd_valid,
    output logic        cmd_apndp,
    output logic        cmd_rnw,
    output logic [1:0]  cmd_addr,
    input  logic [2:0]  rsp_ack,
    input  logic [31:0] rsp_rdata,
    output logic        wr_valid,
    output logic [31:0] wr_data,
    output logic        protocol_err,
    output logic        line_reset_seen
);
    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [32:0] sr, sr_n;
    logic [2:0]  ack_r, ack_n;
    logic [6:0]  req_bits;
    logic [1:0]  addr_n;
    logic [31:0] wr_data_n;
    logic        req_ok, sat, hit;
    logic        out_n, oe_n, cmd_valid_n, err_n, wr_valid_n, apndp_n, rnw_n;

    swd_line_reset_detector #(.LINE_RESET_CYCLES(LINE_RESET_CYCLES)) u_lrd (
        .swclk(swclk),
        .rst(rst),
        .swdio_in(swdio_in),
        .swdio_oe(swdio_oe),
        .sat(sat),
        .hit(hit),
        .line_reset_seen(line_reset_seen)
    );

    // Six earlier request bits sit at the top of the shift register when the park bit arrives.
    assign req_bits = {swdio_in, sr[32:27]};
    assign req_ok   = (req_bits[REQ_PAR] == ^req_bits[REQ_A3:REQ_APNDP]) && !req_bits[REQ_STOP] && req_bits[REQ_PARK];

    always_ff @(posedge swclk or posedge rst) begin
        if (rst) begin
            state        <= LRST;
            cnt          <= '0;
            sr           <= '0;
            ack_r        <= '0;
            swdio_out    <= 1'b0;
            swdio_oe     <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_apndp    <= 1'b0;
            cmd_rnw      <= 1'b0;
            cmd_addr     <= '0;
            wr_valid     <= 1'b0;
            wr_data      <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sr           <= sr_n;
            ack_r        <= ack_n;
            swdio_out    <= out_n;
            swdio_oe     <= oe_n;
            cmd_valid    <= cmd_valid_n;
            cmd_apndp    <= apndp_n;
            cmd_rnw      <= rnw_n;
            cmd_addr     <= addr_n;
            wr_valid     <= wr_valid_n;
            wr_data      <= wr_data_n;
            protocol_err <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = '0;
        sr_n        = sr;
        ack_n       = ack_r;
        out_n       = 1'b0;
        oe_n        = 1'b0;
        cmd_valid_n = 1'b0;
        err_n       = 1'b0;
        wr_valid_n  = 1'b0;
        wr_data_n   = wr_data;
        apndp_n     = cmd_apndp;
        rnw_n       = cmd_rnw;
        addr_n      = cmd_addr;
        case (state)
            LRST: state_n = (sat && !swdio_in) ? IDLE : LRST;
            IDLE: state_n = swdio_in ? REQ : IDLE;
            REQ: begin
                sr_n  = {swdio_in, sr[32:1]};
                cnt_n = cnt + 6'd1;
                if (cnt == 6'd6) begin
                    state_n     = req_ok ? TRN1 : IDLE;
                    cnt_n       = '0;
                    cmd_valid_n = req_ok;
                    err_n       = !req_ok;
                    if (req_ok) {apndp_n, rnw_n, addr_n} = {req_bits[REQ_APNDP], req_bits[REQ_RNW], req_bits[REQ_A3], req_bits[REQ_A2]};
                end
            end
            TRN1: begin
                state_n = ACK;
                ack_n   = rsp_ack;
                sr_n    = {^rsp_rdata, rsp_rdata};
                out_n   = rsp_ack[0];
                oe_n    = 1'b1;
            end
            ACK: begin
                cnt_n = cnt + 6'd1;
                oe_n  = 1'b1;
                out_n = cnt[0] ? ack_r[2] : ack_r[1];
                if (cnt == 6'd2) begin
                    state_n = (ack_r != OK) ? TRN2 : cmd_rnw ? RDATA : WTRN;
                    cnt_n   = '0;
                    oe_n    = ack_r == OK && cmd_rnw;
                    out_n   = oe_n && sr[0];
                end
            end
            RDATA: begin
                cnt_n = cnt + 6'd1;
                sr_n  = {1'b0, sr[32:1]};
                oe_n  = cnt != 6'd32;
                out_n = oe_n && sr[1];
                state_n = (cnt == 6'd32) ? TRN2 : RDATA;
            end
            WTRN: state_n = WDATA;
            WDATA: begin
                sr_n  = {swdio_in, sr[32:1]};
                cnt_n = cnt + 6'd1;
                if (cnt == 6'd32) begin
                    state_n = IDLE;
                    cnt_n   = '0;
`ifdef SWD_WDATA_PARITY_CHECK_EN
                    wr_valid_n = (^sr[32:1]) == swdio_in;
                    err_n      = !wr_valid_n;
                    wr_data_n  = wr_valid_n ? sr[32:1] : wr_data;
`else
                    wr_valid_n = 1'b1;
                    wr_data_n  = sr[32:1];
`endif
                end
            end
            TRN2: state_n = IDLE;
            default: state_n = LRST;
        endcase
        if (hit) begin
            state_n     = LRST;
            cnt_n       = '0;
            out_n       = 1'b0;
            oe_n        = 1'b0;
            cmd_valid_n = 1'b0;
            err_n       = 1'b0;
            wr_valid_n  = 1'b0;
            wr_data_n   = wr_data;
        end
    end
endmodule

// File: tb/tb_swd_target_responder.sv
// tb_swd_target_responder: directed host-side frames against swd_target_responder with hand-computed expectations.
module tb_swd_target_responder;
    import swd_target_pkg::*;

    logic        swclk = 1'b0;
    logic        rst = 1'b1;
    logic        swdio_in = 1'b0;
    logic        swdio_out, swdio_oe, cmd_valid, cmd_apndp, cmd_rnw;
    logic        wr_valid, protocol_err, line_reset_seen;
    logic [1:0]  cmd_addr;
    logic [2:0]  rsp_ack = 3'b001;
    logic [31:0] rsp_rdata = 32'h2BA01477;
    logic [31:0] wr_data;
    logic [35:0] seq;
    logic [2:0]  ack_bits;
    logic        any_oe = 1'b0;
    logic        any_cv = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;

    always #5 swclk = ~swclk;

    swd_target_responder dut (
        .swclk(swclk),
        .rst(rst),
        .swdio_in(swdio_in),
        .swdio_out(swdio_out),
        .swdio_oe(swdio_oe),
        .cmd_valid(cmd_valid),
        .cmd_apndp(cmd_apndp),
        .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr),
        .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .protocol_err(protocol_err),
        .line_reset_seen(line_reset_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host bit: drive after the falling edge, observe 1 time unit after the sampling edge.
    task automatic host(input logic b);
        @(negedge swclk);
        swdio_in = b;
        @(posedge swclk);
        #1;
        any_oe |= swdio_oe;
        any_cv |= cmd_valid;
        pulses += int'(line_reset_seen);
    endtask

    task automatic req(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) host(v[i]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic p);
        for (int i = 0; i < 32; i++) host(w[i]);
        host(p);
    endtask

    task automatic line_reset(input int n);
        pulses = 0;
        repeat (n) host(1'b1);
        host(1'b0);
    endtask

    initial begin
        #12;
        chk("reset_oe", swdio_oe, 0);
        chk("reset_out", swdio_out, 0);
        chk("reset_cmd_valid", cmd_valid, 0);
        chk("reset_wr_valid", wr_valid, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_err", protocol_err, 0);
        chk("reset_lrs", line_reset_seen, 0);
        rst = 1'b0;
        // Requests are ignored until a line reset has been seen.
        any_oe = 1'b0;
        any_cv = 1'b0;
        req(8'b10100101);
        repeat (4) host(1'b0);
        chk("lrst_no_oe", any_oe, 0);
        chk("lrst_no_cmd", any_cv, 0);
        line_reset(55);
        chk("line_reset_pulses", pulses, 1);
        // DP read
        rsp_ack = 3'b001;
        rsp_rdata = 32'h2BA01477;
        req(8'b10100101);
        chk("rd_cmd_valid", cmd_valid, 1);
        chk("rd_rnw", cmd_rnw, 1);
        chk("rd_apndp", cmd_apndp, 0);
        chk("rd_addr", cmd_addr, 0);
        chk("rd_trn1_oe", swdio_oe, 0);
        host(1'b0);
        chk("rd_cmd_valid_once", cmd_valid, 0);
        seq = {1'b0, 32'h2BA01477, 3'b001};
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("rd_oe%0d", i), swdio_oe, 1);
            chk($sformatf("rd_bit%0d", i), swdio_out, seq[i]);
            host(1'b0);
        end
        chk("rd_release", swdio_oe, 0);
        chk("rd_release_out", swdio_out, 0);
        host(1'b0);
        chk("rd_idle_oe", swdio_oe, 0);
        // AP write
        req(8'b11010001);
        chk("wr_cmd_valid", cmd_valid, 1);
        chk("wr_apndp", cmd_apndp, 1);
        chk("wr_rnw", cmd_rnw, 0);
        chk("wr_addr", cmd_addr, 2'b01);
        repeat (4) host(1'b0);
        chk("wr_wtrn_oe", swdio_oe, 0);
        host(1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        chk("wr_valid", wr_valid, 1);
        chk("wr_data", wr_data, 32'hDEADBEEF);
        chk("wr_no_err", protocol_err, 0);
        host(1'b0);
        chk("wr_valid_once", wr_valid, 0);
        chk("wr_data_hold", wr_data, 32'hDEADBEEF);
        // Malformed request, then WAIT
        any_oe = 1'b0;
        req(8'b10100001);
        chk("bad_req_err", protocol_err, 1);
        chk("bad_req_cmd", cmd_valid, 0);
        host(1'b0);
        chk("bad_req_err_once", protocol_err, 0);
        chk("bad_req_no_oe", any_oe, 0);
        rsp_ack = 3'b010;
        ack_bits = 3'b010;
        req(8'b10100101);
        chk("wait_cmd_valid", cmd_valid, 1);
        host(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait_oe%0d", i), swdio_oe, 1);
            chk($sformatf("wait_ack%0d", i), swdio_out, ack_bits[i]);
            host(1'b0);
        end
        chk("wait_release", swdio_oe, 0);
        any_oe = 1'b0;
        repeat (3) host(1'b0);
        chk("wait_no_data", any_oe, 0);
        // Write with bad parity
        rsp_ack = 3'b001;
        req(8'b11010001);
        repeat (5) host(1'b0);
        send_word(32'hDEADBEEF, 1'b1);
`ifdef SWD_WDATA_PARITY_CHECK_EN
        chk("wpar_wr_valid", wr_valid, 0);
        chk("wpar_err", protocol_err, 1);
`else
        chk("wpar_wr_valid", wr_valid, 1);
        chk("wpar_err", protocol_err, 0);
`endif
        chk("wpar_wr_data", wr_data, 32'hDEADBEEF);
        host(1'b0);
        // Reset in the middle of a read data phase
        req(8'b10100101);
        repeat (14) host(1'b0);
        chk("mid_rd_oe", swdio_oe, 1);
        chk("mid_rd_bit10", swdio_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", swdio_oe, 0);
        chk("mid_rst_out", swdio_out, 0);
        @(negedge swclk);
        rst = 1'b0;
        any_oe = 1'b0;
        any_cv = 1'b0;
        req(8'b10100101);
        repeat (4) host(1'b0);
        chk("post_rst_no_oe", any_oe, 0);
        chk("post_rst_no_cmd", any_cv, 0);
        line_reset(50);
        chk("post_rst_lr_pulses", pulses, 1);
        req(8'b10100101);
        chk("post_lr_cmd_valid", cmd_valid, 1);
        repeat (2) host(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/swd_target_responder.md
Name: swd_target_responder

Overview:
- Target-side (DP-end) SWD serial engine: the counterpart to our probe frontend.
- Decodes 8-bit host requests on SWDIO and drives turnaround, ACK and read data back.
- Captures write data and hands the decoded transactions to a register backend via one-cycle strobes.
- Used as a loopback/emulated target for bring-up of the probe.

Parameters:
- LINE_RESET_CYCLES, 50: consecutive sampled 1s (host-driven) that constitute a line reset.

Ports:
- swclk  in  1  sole clock; all flops on rising edge. Host changes SWDIO off the falling edge.
- rst  in  1  asynchronous, active-high reset.
- swdio_in  in  1  sampled SWDIO pad.
- swdio_out  out  1  target data to pad, registered.
- swdio_oe  out  1  pad drive enable, registered.
- cmd_valid  out  1  one-cycle strobe: valid request decoded.
- cmd_apndp  out  1  request APnDP.
- cmd_rnw  out  1  request RnW.
- cmd_addr  out  2  request {A3,A2}.
- rsp_ack  in  3  backend ACK {FAULT,WAIT,OK}; sampled at end of cmd_valid cycle.
- rsp_rdata  in  32  read data; sampled with rsp_ack.
- wr_valid  out  1  one-cycle strobe: write data captured.
- wr_data  out  32  captured write data; holds until next write.
- protocol_err  out  1  one-cycle pulse: malformed request.
- line_reset_seen  out  1  one-cycle pulse: line reset detected.

Behaviour:
- Reset: all outputs 0, state LRST, ones counter 0.
- Ones counter:
  - Increments on each sample with swdio_oe=0 and swdio_in=1; saturates at LINE_RESET_CYCLES.
  - Clears on any 0 sample.
  - Clears while swdio_oe=1, because that sample is the target's own echo.
- Line reset:
  - When the counter reaches LINE_RESET_CYCLES in any non-driving state: go to LRST and pulse line_reset_seen once (re-arms only after a 0).
- LRST: ignore requests; leave to IDLE on the first 0 sampled after the counter saturated.
- IDLE: a sampled 1 is the start bit; go to REQ.
- REQ:
  - Shift 7 bits LSB-first: APnDP, RnW, A2, A3, parity, stop, park.
  - On the park edge, check parity == APnDP^RnW^A2^A3, stop == 0, park == 1.
  - Pass: go to TRN1 with cmd_* registered.
  - Fail: pulse protocol_err, go to IDLE, swdio_oe stays 0.
- TRN1: one cycle, oe=0; cmd_valid=1 for exactly this cycle. Backend must present rsp_ack/rsp_rdata combinationally within it.
- ACK:
  - oe=1 for 3 cycles, driving rsp_ack[0], [1], [2].
  - Any rsp_ack value is driven verbatim.
  - Only 3'b001 (OK) continues to a data phase.
- RDATA (OK read): oe=1 for 33 cycles: rdata[0..31], then even parity (XOR of all 32 bits). Then TRN2.
- WTRN (OK write): one cycle, oe=0; then WDATA.
- WDATA:
  - Sample 33 bits (data LSB-first, then parity).
  - On the parity edge, assert wr_valid next cycle with wr_data; go to IDLE.
- Non-OK ACK: go to TRN2; no data phase; no wr_valid.
- TRN2: one cycle, oe=0; then IDLE.
- swdio_out is 0 whenever oe=0.
- Bit counter is 6 bits; no wrap is reachable.
- Reset mid-frame: immediate oe=0, state LRST, any pending strobe discarded.

Optional Feature:
- Macro SWD_WDATA_PARITY_CHECK_EN.
  - Defined: on write parity mismatch, suppress wr_valid, keep old wr_data, and pulse protocol_err.
  - Undefined: parity bit ignored; wr_valid always fires.

Decomposition:
- Package swd_target_pkg holds:
  - state enum: LRST, IDLE, REQ, TRN1, ACK, RDATA, TRN2, WTRN, WDATA;
  - ACK constants OK=3'b001, WAIT=3'b010, FAULT=3'b100;
  - request bit positions;
  - default LINE_RESET_CYCLES.
- Sub-module swd_line_reset_detector: saturating ones counter, oe gating, and line_reset_seen pulse with re-arm.

Test Plan:
- Line reset gating:
  - Stimulus: rst pulse; valid request without a line reset; then 50 ones + 0.
  - Response: no oe during the request; line_reset_seen pulses once; state IDLE.
- DP read:
  - Stimulus: request bits 1,0,1,0,0,1,0,1; rsp_ack=001; rdata=0x2BA01477.
  - Response: cmd_valid 1 cycle (rnw=1, addr=0); oe high 36 cycles; SWDIO = 1,0,0, then data LSB-first, then parity 0; one released cycle.
- AP write:
  - Stimulus: request 1,1,0,1,0,0,0,1; ACK OK; host sends 0xDEADBEEF with parity 0.
  - Response: wr_valid once; wr_data=0xDEADBEEF; cmd_addr=2'b01.
- Malformed request and WAIT:
  - Stimulus: bad request parity, then a valid read with rsp_ack=010.
  - Response: protocol_err pulse with no oe; second request gives 3 ACK cycles then release, no data phase.
- Write parity error:
  - Stimulus: 0xDEADBEEF sent with parity 1.
  - Response with macro: no wr_valid, protocol_err pulse.
  - Response without macro: wr_valid fires.
- Reset mid-read:
  - Stimulus: assert rst at RDATA bit 10.
  - Response: oe=0 immediately; the next frame is ignored until a line reset.
